// File: rtl/seg_scan_controller_if.sv
// ---------------------------------------------------------------------------
// seg_scan_controller_if
//   Bundles the value/display signals of the seven-segment scan controller.
//
//   Signals
//     en          1 = scan, 0 = display dark
//     value       packed nibbles, digit 0 in value[3:0] (rightmost digit)
//     dp_mask     1 = light decimal point of digit i
//     hex_out     nibble presented to the shared hex decoder
//     seg_in      decoder segments {g..a}, active-low, combinational from hex_out
//     seg_out     gated segments to the pins, active-low
//     dp_out      decimal point, active-low
//     an_out      anodes, active-low, at most one low
//     digit_idx   index of the digit currently selected
//     frame_tick  one-cycle pulse at the start of each frame
//
//   Modports
//     master  the scan controller (drives the display side)
//     slave   the system / board side (drives en, value, dp_mask, seg_in)
// ---------------------------------------------------------------------------
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [3:0]                hex_out;
    logic [6:0]                seg_in;
    logic [6:0]                seg_out;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     an_out;
    logic [2:0]                digit_idx;
    logic                      frame_tick;

    modport master (
        input  en, value, dp_mask, seg_in,
        output hex_out, seg_out, dp_out, an_out, digit_idx, frame_tick
    );

    modport slave (
        output en, value, dp_mask, seg_in,
        input  hex_out, seg_out, dp_out, an_out, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_controller.sv
// ---------------------------------------------------------------------------
// seg_scan_controller
//   Time-multiplexes one shared combinational hex-to-seven-segment decoder
//   across NUM_DIGITS common-anode digits. Each digit gets a BLANK slot (all
//   anodes off, decoder nibble settles) followed by an ON slot (its anode low,
//   decoder segments passed to the pins).
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-high
//     bus    seg_scan_controller_if.master (en, value, dp_mask, seg_in in;
//            hex_out, seg_out, dp_out, an_out, digit_idx, frame_tick out)
//
//   Parameters
//     NUM_DIGITS    digits scanned, 2..8
//     ON_CYCLES     clk cycles each digit is lit, >= 1
//     BLANK_CYCLES  clk cycles all anodes are off before each digit, >= 1
//
//   Build option
//     LEADING_ZERO_BLANK_EN  when defined, leading zero digits (i > 0, no
//                            decimal point) stay dark during their ON slot.
// ---------------------------------------------------------------------------
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    seg_scan_controller_if.master   bus
);

    localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] ON_LOAD    = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t                    r_state;
    logic [TW-1:0]             r_timer;
    logic [4*NUM_DIGITS-1:0]   r_snap;
    logic [NUM_DIGITS-1:0]     r_dp_snap;
    logic [NUM_DIGITS-1:0]     r_blank;
    logic [2:0]                r_idx;
    logic [3:0]                r_hex;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_dp;
    logic                      r_lit;
    logic                      r_tick;

    logic [NUM_DIGITS-1:0]     w_sel;
    logic                      w_cur_blank;
    logic                      w_cur_dp;
    logic                      w_start;
    logic [NUM_DIGITS-1:0]     w_blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic                      w_zero;
`endif

    // Select nibble i of a packed value without an oversized dynamic index.
    function automatic logic [3:0] nibble(input logic [4*NUM_DIGITS-1:0] v,
                                          input logic [2:0] i);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (3'(k) == i) n = v[4*k +: 4];
        end
        return n;
    endfunction

    // One-hot mask of the selected digit; used for anode, dp and blank lookup.
    assign w_sel       = NUM_DIGITS'(1) << r_idx;
    assign w_cur_blank = |(r_blank & w_sel);
    assign w_cur_dp    = |(r_dp_snap & w_sel);

    // A new frame begins from IDLE, or after the last digit's ON slot expires.
    assign w_start = bus.en &&
                     ((r_state == IDLE) ||
                      (r_state == ON && r_timer == '0 && r_idx == LAST_IDX));

    // Leading-zero mask, evaluated against the live inputs and captured with
    // the frame snapshot. Scans from the top digit down; digit 0 never blanks.
    always_comb begin
        w_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        w_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero     = w_zero & (bus.value[4*k +: 4] == 4'd0);
            w_blank[k] = w_zero & ~bus.dp_mask[k];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_snap    <= '0;
            r_dp_snap <= '0;
            r_blank   <= '0;
            r_idx     <= 3'd0;
            r_hex     <= 4'd0;
            r_an      <= '1;
            r_dp      <= 1'b1;
            r_lit     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (!bus.en) begin
                r_state <= IDLE;
                r_timer <= '0;
                r_idx   <= 3'd0;
                r_an    <= '1;
                r_dp    <= 1'b1;
                r_lit   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    BLANK: begin
                        if (r_timer == '0) begin
                            r_state <= ON;
                            r_timer <= ON_LOAD;
                            r_an    <= w_cur_blank ? '1 : ~w_sel;
                            r_lit   <= ~w_cur_blank;
                            r_dp    <= ~(w_cur_dp & ~w_cur_blank);
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    ON: begin
                        if (r_timer == '0) begin
                            r_state <= BLANK;
                            r_timer <= BLANK_LOAD;
                            r_an    <= '1;
                            r_lit   <= 1'b0;
                            r_dp    <= 1'b1;
                            // hex_out moves only on BLANK entry so the decoder
                            // output settles while all anodes are off.
                            r_idx   <= r_idx + 3'd1;
                            r_hex   <= nibble(r_snap, r_idx + 3'd1);
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase

                // Frame start overrides the digit advance of the last ON slot.
                if (w_start) begin
                    r_state   <= BLANK;
                    r_timer   <= BLANK_LOAD;
                    r_idx     <= 3'd0;
                    r_snap    <= bus.value;
                    r_dp_snap <= bus.dp_mask;
                    r_blank   <= w_blank;
                    r_hex     <= bus.value[3:0];
                    r_tick    <= 1'b1;
                end
            end
        end
    end

    assign bus.hex_out    = r_hex;
    assign bus.seg_out    = r_lit ? bus.seg_in : 7'h7F;
    assign bus.dp_out     = r_dp;
    assign bus.an_out     = r_an;
    assign bus.digit_idx  = r_idx;
    assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_controller
//   Directed bench for seg_scan_controller with NUM_DIGITS=4, ON_CYCLES=4,
//   BLANK_CYCLES=2 and a behavioural hex decoder driving seg_in.
//   Each frame is 24 cycles: per digit 2 dark cycles then 4 lit cycles.
// ---------------------------------------------------------------------------
module tb_seg_scan_controller;

    localparam int N  = 4;
    localparam int ON = 4;
    localparam int BL = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LIT_0050 = 4'b0011;
    localparam logic [3:0] LIT_0000 = 4'b0001;
`else
    localparam logic [3:0] LIT_0050 = 4'b1111;
    localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    seg_scan_controller_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_controller #(
        .NUM_DIGITS   (N),
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Active-low {g..a} decoder.
    function automatic logic [6:0] dec7(input logic [3:0] h);
        case (h)
            4'h0: dec7 = 7'h40;  4'h1: dec7 = 7'h79;
            4'h2: dec7 = 7'h24;  4'h3: dec7 = 7'h30;
            4'h4: dec7 = 7'h19;  4'h5: dec7 = 7'h12;
            4'h6: dec7 = 7'h02;  4'h7: dec7 = 7'h78;
            4'h8: dec7 = 7'h00;  4'h9: dec7 = 7'h10;
            4'hA: dec7 = 7'h08;  4'hB: dec7 = 7'h03;
            4'hC: dec7 = 7'h46;  4'hD: dec7 = 7'h21;
            4'hE: dec7 = 7'h06;  default: dec7 = 7'h0E;
        endcase
    endfunction

    assign bus.seg_in = dec7(bus.hex_out);

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // No cycle may ever have more than one anode low.
    always @(negedge clk) begin
        if (mon_on) chk("an_onehot", ($countones(~bus.an_out) <= 1), 1);
    end

    // Called on the first sample of a frame; returns on its last sample.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] dp,
                               input logic [3:0] lit);
        logic [3:0] nib;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       lt;
        for (int d = 0; d < N; d++) begin
            nib = v[4*d +: 4];
            for (int c = 0; c < BL + ON; c++) begin
                lt    = (c >= BL) && lit[d];
                e_an  = lt ? ~(4'b0001 << d) : 4'b1111;
                e_seg = lt ? dec7(nib) : 7'h7F;
                e_dp  = (lt && dp[d]) ? 1'b0 : 1'b1;
                chk($sformatf("tick d%0d c%0d", d, c), bus.frame_tick, (d == 0 && c == 0));
                chk($sformatf("idx d%0d c%0d", d, c), bus.digit_idx, d);
                chk($sformatf("hex d%0d c%0d", d, c), bus.hex_out, nib);
                chk($sformatf("an d%0d c%0d", d, c), bus.an_out, e_an);
                chk($sformatf("seg d%0d c%0d", d, c), bus.seg_out, e_seg);
                chk($sformatf("dp d%0d c%0d", d, c), bus.dp_out, e_dp);
                if (!(d == N - 1 && c == BL + ON - 1)) step();
            end
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"},   bus.an_out, 4'b1111);
        chk({tag, "_seg"},  bus.seg_out, 7'h7F);
        chk({tag, "_dp"},   bus.dp_out, 1'b1);
        chk({tag, "_idx"},  bus.digit_idx, 3'd0);
        chk({tag, "_tick"}, bus.frame_tick, 1'b0);
    endtask

    initial begin
        bus.en      = 1'b0;
        bus.value   = 16'h0000;
        bus.dp_mask = 4'b0000;

        // Reset state
        step();
        step();
        chk_dark("rst");
        chk("rst_hex", bus.hex_out, 4'h0);
        @(negedge clk);
        reset  = 1'b0;
        mon_on = 1'b1;
        step();
        chk_dark("idle");

        // Basic scan; value changes mid-frame must not tear
        bus.value = 16'h1234;
        bus.en    = 1'b1;
        step();
        bus.value = 16'hABCD;
        check_frame(16'h1234, 4'b0000, 4'b1111);

        // Next frame shows the new value; dp_mask change mid-frame is deferred
        step();
        bus.dp_mask = 4'b0100;
        check_frame(16'hABCD, 4'b0000, 4'b1111);
        step();
        check_frame(16'hABCD, 4'b0100, 4'b1111);

        // Drop en during digit 2 ON
        step();
        chk("en_tick", bus.frame_tick, 1'b1);
        repeat (14) step();
        chk("en_d2_an", bus.an_out, 4'b1011);
        bus.en = 1'b0;
        step();
        chk_dark("en_off");
        step();
        chk_dark("en_off2");
        bus.en = 1'b1;
        step();
        check_frame(16'hABCD, 4'b0100, 4'b1111);

        // Asynchronous reset in digit 1 BLANK
        step();
        repeat (6) step();
        chk("pre_rst_idx", bus.digit_idx, 3'd1);
        reset = 1'b1;
        #1;
        chk_dark("arst");
        chk("arst_hex", bus.hex_out, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_frame(16'hABCD, 4'b0100, 4'b1111);

        // Leading-zero cases
        bus.value   = 16'h0050;
        bus.dp_mask = 4'b0000;
        step();
        check_frame(16'h0050, 4'b0000, LIT_0050);
        bus.value = 16'h0000;
        step();
        check_frame(16'h0000, 4'b0000, LIT_0000);

        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
